// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response handshake plus memory-side bus for mem_access_ctrl.
// The controller uses the slave modport; the CPU/memory side uses master.
interface mem_access_ctrl_if;
    logic       req_valid;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_fault;
    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_data, resp_fault,
               mem_address, mem_write, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_data, resp_fault,
               mem_address, mem_write, mem_data_in
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the 8-bit CPU's 256-byte map.
// Define MEM_ACCESS_FAULT_EN to suppress ROM stores / output-port loads and flag them on resp_fault.
module mem_access_ctrl (
    input  logic             clk,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       resp_valid_q, resp_valid_d;
    logic       fault_acc;

`ifdef MEM_ACCESS_FAULT_EN
    logic fault_q, fault_d;
    logic resp_fault_q, resp_fault_d;

    // Violation is classified once at accept and held for the whole access.
    always_comb begin
        fault_d = fault_q;
        if (state_q == IDLE && bus.req_valid)
            fault_d = bus.req_write ? ~bus.req_addr[7] : (bus.req_addr[7:4] == 4'hF);
    end

    assign resp_fault_d = fault_q && (state_q == RD_DATA || state_q == WR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_q      <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            fault_q      <= fault_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign fault_acc      = fault_q;
    assign bus.resp_fault = resp_fault_q;
`else
    assign fault_acc      = 1'b0;
    assign bus.resp_fault = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        resp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = bus.req_write ? WR : RD_ADDR;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                rdata_d      = fault_acc ? 8'h00 : bus.mem_data_out;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            WR: begin
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Strobes decode from state alone so an async reset drops them immediately.
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.mem_write   = (state_q == WR) && !fault_acc;
    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed table plus randomized transactions against a map-level reference model.
module tb_mem_access_ctrl;
    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_data;
        logic       exp_fault;
        int         exp_lat;
        int         exp_mw;
    } vec_t;

    logic       clk;
    logic       reset;
    int         n_checks = 0;
    int         n_err    = 0;
    int         mw_cnt   = 0;
    bit         do_init;
    logic [7:0] env_mem [256];
    logic [7:0] rd_q;
    logic [7:0] inport  [16];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rdata;
    vec_t       tbl [10];

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [7:0] a);
        return (a == 8'h85) ? 8'h3C : (a ^ 8'hC3);
    endfunction

    // Memory block: ROM/RW read registered, RW writable, ports combinational.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_byte(8'(i));
        end else if (bus.mem_write && bus.mem_address >= 8'h80 && bus.mem_address < 8'hE0) begin
            env_mem[bus.mem_address] <= bus.mem_data_in;
        end
        rd_q <= env_mem[bus.mem_address];
    end

    always_comb begin
        if (bus.mem_address < 8'hE0)      bus.mem_data_out = rd_q;
        else if (bus.mem_address < 8'hF0) bus.mem_data_out = inport[bus.mem_address[3:0]];
        else                              bus.mem_data_out = bus.mem_address ^ 8'h5A;
    end

    always @(negedge clk) if (bus.mem_write === 1'b1) mw_cnt <= mw_cnt + 1;

    // Reference model: map-level semantics, one call per transaction in issue order.
    function automatic vec_t model(input logic w, input logic [7:0] a, input logic [7:0] d);
        vec_t v;
        logic f;
        v.w = w; v.a = a; v.d = d;
`ifdef MEM_ACCESS_FAULT_EN
        f = w ? (a < 8'h80) : (a >= 8'hF0);
`else
        f = 1'b0;
`endif
        v.exp_fault = f;
        v.exp_lat   = w ? 2 : 3;
        v.exp_mw    = (w && !f) ? 1 : 0;
        if (w) begin
            v.exp_data = last_rdata;
            if (!f && a >= 8'h80 && a < 8'hE0) ref_mem[a] = d;
        end else begin
            if (f)              v.exp_data = 8'h00;
            else if (a < 8'hE0) v.exp_data = ref_mem[a];
            else if (a < 8'hF0) v.exp_data = inport[a[3:0]];
            else                v.exp_data = a ^ 8'h5A;
            last_rdata = v.exp_data;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with req_ready expected high; returns #1 after the response edge.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int mw0;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.w;
        bus.req_addr  = v.a;
        bus.req_wdata = v.d;
        mw0 = mw_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ~v.a;
        bus.req_wdata = ~v.d;
        check({tag, "_addr"}, 32'(bus.mem_address), 32'(v.a));
        if (v.w) check({tag, "_wdata"}, 32'(bus.mem_data_in), 32'(v.d));
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"},   32'(lat),            32'(v.exp_lat));
        check({tag, "_data"},  32'(bus.resp_data),  32'(v.exp_data));
        check({tag, "_fault"}, 32'(bus.resp_fault), 32'(v.exp_fault));
        check({tag, "_mwcnt"}, 32'(mw_cnt - mw0),   32'(v.exp_mw));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 16; i++) inport[i] = 8'h00;
        inport[3] = 8'h7E;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(8'(i));
        last_rdata = 8'h00;

        tbl[0] = '{1'b0, 8'h85, 8'h00, 8'h3C, 1'b0, 3, 0};
        tbl[1] = '{1'b1, 8'h90, 8'hA5, 8'h3C, 1'b0, 2, 1};
        tbl[2] = '{1'b0, 8'h90, 8'h00, 8'hA5, 1'b0, 3, 0};
        tbl[3] = '{1'b0, 8'hE3, 8'h00, 8'h7E, 1'b0, 3, 0};
`ifdef MEM_ACCESS_FAULT_EN
        tbl[4] = '{1'b1, 8'h10, 8'h11, 8'h7E, 1'b1, 2, 0};
        tbl[5] = '{1'b0, 8'h10, 8'h00, 8'hD3, 1'b0, 3, 0};
        tbl[6] = '{1'b0, 8'hF4, 8'h00, 8'h00, 1'b1, 3, 0};
        tbl[7] = '{1'b1, 8'hF7, 8'h5A, 8'h00, 1'b0, 2, 1};
`else
        tbl[4] = '{1'b1, 8'h10, 8'h11, 8'h7E, 1'b0, 2, 1};
        tbl[5] = '{1'b0, 8'h10, 8'h00, 8'hD3, 1'b0, 3, 0};
        tbl[6] = '{1'b0, 8'hF4, 8'h00, 8'hAE, 1'b0, 3, 0};
        tbl[7] = '{1'b1, 8'hF7, 8'h5A, 8'hAE, 1'b0, 2, 1};
`endif
        tbl[8] = '{1'b0, 8'hDF, 8'h00, 8'h1C, 1'b0, 3, 0};
        tbl[9] = '{1'b0, 8'h7F, 8'h00, 8'hBC, 1'b0, 3, 0};

        // Reset held with a request pending: nothing may be accepted.
        reset         = 1'b1;
        do_init       = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h85;
        bus.req_wdata = 8'h00;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_init = 1'b0;
        check("rst_ready",  32'(bus.req_ready),   32'd1);
        check("rst_rvalid", 32'(bus.resp_valid),  32'd0);
        check("rst_rdata",  32'(bus.resp_data),   32'd0);
        check("rst_rfault", 32'(bus.resp_fault),  32'd0);
        check("rst_mwrite", 32'(bus.mem_write),   32'd0);
        check("rst_maddr",  32'(bus.mem_address), 32'd0);
        check("rst_mdin",   32'(bus.mem_data_in), 32'd0);
        reset = 1'b1;

        // Directed table, issued back-to-back from each response cycle.
        for (int i = 0; i < 10; i++) begin
            v = model(tbl[i].w, tbl[i].a, tbl[i].d);
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 150; n++) begin
            logic       w;
            logic [7:0] a;
            logic [7:0] d;
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(8'h00, 8'h7F));
                1:       a = 8'($urandom_range(8'h80, 8'hDF));
                2:       a = 8'($urandom_range(8'hE0, 8'hEF));
                default: a = 8'($urandom_range(8'hF0, 8'hFF));
            endcase
            inport[$urandom_range(0, 15)] = 8'($urandom);
            v = model(w, a, d);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a store's WR cycle.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h88;
        bus.req_wdata = 8'h77;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_mw_before", 32'(bus.mem_write), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_mw_async",  32'(bus.mem_write), 32'd0);
        check("abort_ready",     32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_rvalid0",   32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_rvalid1",   32'(bus.resp_valid),  32'd0);
        check("abort_rdata",     32'(bus.resp_data),   32'd0);
        check("abort_maddr",     32'(bus.mem_address), 32'd0);
        last_rdata = 8'h00;
        reset = 1'b1;
        v = model(1'b0, 8'h88, 8'h00);
        run_vec(v, "abort_reload");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
